// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand-fetch stage: register names and stage FSM states.
package operand_fetch_pkg;

    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned REG_IDX_W = $clog2(REG_COUNT);

    typedef logic [REG_IDX_W-1:0] regName_t;

    typedef enum logic [1:0] {
        OF_IDLE,
        OF_READ,
        OF_HOLD
    } of_state_t;

endpackage

// File: rtl/operand_fetch_bypass.sv
// operand_bypass: per-operand priority mux that picks between x0, the live
// writeback, a writeback captured on the accept edge, and register-file data.
module operand_bypass
    import operand_fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  regName_t              rs_i,
    input  logic                  wb_wen_i,
    input  regName_t              wb_rd_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  byp_hit_i,
    input  logic [DATA_WIDTH-1:0] byp_d_i,
    input  logic [DATA_WIDTH-1:0] rf_data_i,
    output logic [DATA_WIDTH-1:0] op_o
);

    // Youngest value wins: live writeback, then the write missed by the RF read, then RF.
    always_comb begin
        op_o = rf_data_i;
        if (rs_i == '0) begin
            op_o = '0;
        end else if (wb_wen_i && (wb_rd_i == rs_i)) begin
            op_o = wb_data_i;
        end else if (byp_hit_i) begin
            op_o = byp_d_i;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: decode-to-execute stage. Drives synchronous-read RF addresses,
// absorbs the one-cycle read latency, bypasses writebacks and holds operands
// while execute stalls.
// Optional: define OPERAND_FETCH_STALL_CNT_EN to add the 32-bit stall_cnt output.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CTRL_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  regName_t              dec_rs1,
    input  regName_t              dec_rs2,
    input  regName_t              dec_rd,
    input  logic [DATA_WIDTH-1:0] dec_imm,
    input  logic [CTRL_WIDTH-1:0] dec_ctrl,
    output regName_t              rf_rs1,
    output regName_t              rf_rs2,
    input  logic [DATA_WIDTH-1:0] rf_a,
    input  logic [DATA_WIDTH-1:0] rf_b,
    input  logic                  wb_wen,
    input  regName_t              wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [DATA_WIDTH-1:0] ex_op_a,
    output logic [DATA_WIDTH-1:0] ex_op_b,
    output regName_t              ex_rd,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [CTRL_WIDTH-1:0] ex_ctrl
`ifdef OPERAND_FETCH_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    of_state_t             state_q;
    logic                  ex_valid_q;
    regName_t              rs1_q, rs2_q, rd_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [CTRL_WIDTH-1:0] ctrl_q;
    logic                  byp_hit1_q, byp_hit2_q;
    logic [DATA_WIDTH-1:0] byp_d1_q, byp_d2_q;
    logic [DATA_WIDTH-1:0] op_a_q, op_b_q;
    logic [DATA_WIDTH-1:0] op_a_d, op_b_d;
    logic [DATA_WIDTH-1:0] byp_a, byp_b;
    logic                  accept;

    // Ready is forced low while reset is asserted so nothing is accepted then.
    assign dec_ready = rstN & (~ex_valid_q | ex_ready);
    assign accept    = dec_valid & dec_ready;

    // Address the RF with the incoming instruction on accept, else keep tracking the held one.
    assign rf_rs1 = accept ? dec_rs1 : rs1_q;
    assign rf_rs2 = accept ? dec_rs2 : rs2_q;

    operand_bypass #(.DATA_WIDTH(DATA_WIDTH)) u_byp_a (
        .rs_i      (rs1_q),
        .wb_wen_i  (wb_wen),
        .wb_rd_i   (wb_rd),
        .wb_data_i (wb_data),
        .byp_hit_i (byp_hit1_q),
        .byp_d_i   (byp_d1_q),
        .rf_data_i (rf_a),
        .op_o      (byp_a)
    );

    operand_bypass #(.DATA_WIDTH(DATA_WIDTH)) u_byp_b (
        .rs_i      (rs2_q),
        .wb_wen_i  (wb_wen),
        .wb_rd_i   (wb_rd),
        .wb_data_i (wb_data),
        .byp_hit_i (byp_hit2_q),
        .byp_d_i   (byp_d2_q),
        .rf_data_i (rf_b),
        .op_o      (byp_b)
    );

    // Next held operands: snapshot of the bypass mux on entering hold, then writeback snooping.
    always_comb begin
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        if (state_q == OF_READ) begin
            op_a_d = byp_a;
            op_b_d = byp_b;
        end else begin
            if (wb_wen && (wb_rd == rs1_q) && (rs1_q != '0)) op_a_d = wb_data;
            if (wb_wen && (wb_rd == rs2_q) && (rs2_q != '0)) op_b_d = wb_data;
        end
    end

    // Capture instruction fields and any writeback the RF read will miss, on accept.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            ctrl_q     <= '0;
            byp_hit1_q <= 1'b0;
            byp_hit2_q <= 1'b0;
            byp_d1_q   <= '0;
            byp_d2_q   <= '0;
        end else if (accept) begin
            rs1_q      <= dec_rs1;
            rs2_q      <= dec_rs2;
            rd_q       <= dec_rd;
            imm_q      <= dec_imm;
            ctrl_q     <= dec_ctrl;
            byp_hit1_q <= wb_wen && (wb_rd == dec_rs1) && (dec_rs1 != '0);
            byp_hit2_q <= wb_wen && (wb_rd == dec_rs2) && (dec_rs2 != '0);
            byp_d1_q   <= wb_data;
            byp_d2_q   <= wb_data;
        end
    end

    // Stage FSM: idle / first cycle on execute / holding stalled operands.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= OF_IDLE;
            ex_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
        end else begin
            case (state_q)
                OF_IDLE: begin
                    if (accept) begin
                        state_q    <= OF_READ;
                        ex_valid_q <= 1'b1;
                    end
                end
                OF_READ, OF_HOLD: begin
                    if (!ex_ready) begin
                        state_q <= OF_HOLD;
                        op_a_q  <= op_a_d;
                        op_b_q  <= op_b_d;
                    end else if (accept) begin
                        state_q <= OF_READ;
                    end else begin
                        state_q    <= OF_IDLE;
                        ex_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= OF_IDLE;
                    ex_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_op_a  = (state_q == OF_HOLD) ? op_a_q : byp_a;
    assign ex_op_b  = (state_q == OF_HOLD) ? op_b_q : byp_b;
    assign ex_rd    = rd_q;
    assign ex_imm   = imm_q;
    assign ex_ctrl  = ctrl_q;

`ifdef OPERAND_FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count cycles where execute is offered operands but does not take them.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stall_cnt_q <= '0;
        end else if (ex_valid_q && !ex_ready) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    // Stall counter not built.
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus random traffic,
// compared every cycle against an architectural register model.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rstN;
    logic          dec_valid, dec_ready;
    regName_t      dec_rs1, dec_rs2, dec_rd;
    logic [DW-1:0] dec_imm;
    logic [CW-1:0] dec_ctrl;
    regName_t      rf_rs1, rf_rs2;
    logic [DW-1:0] rf_a, rf_b;
    logic          wb_wen;
    regName_t      wb_rd;
    logic [DW-1:0] wb_data;
    logic          ex_valid, ex_ready;
    logic [DW-1:0] ex_op_a, ex_op_b, ex_imm;
    regName_t      ex_rd;
    logic [CW-1:0] ex_ctrl;
`ifdef OPERAND_FETCH_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    operand_fetch #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
        .clk(clk), .rstN(rstN),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_imm(dec_imm), .dec_ctrl(dec_ctrl),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_a(rf_a), .rf_b(rf_b),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_rd(ex_rd),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl)
`ifdef OPERAND_FETCH_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // Environment: synchronous-read register file, read-during-write returns old data.
    logic [DW-1:0] rf_mem [REG_COUNT];
    always @(posedge clk) begin
        rf_a <= rf_mem[rf_rs1];
        rf_b <= rf_mem[rf_rs2];
        if (wb_wen) rf_mem[wb_rd] <= wb_data;
    end

    // Reference model: architectural registers plus the instruction on execute.
    logic [DW-1:0] m_regs [REG_COUNT];
    logic          m_valid, m_held;
    regName_t      m_rs1, m_rs2, m_rd;
    logic [DW-1:0] m_imm;
    logic [CW-1:0] m_ctrl;
    int unsigned   m_stall;
    int            n_pass = 0;
    int            n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // First cycle on execute sees the live writeback; later (held) cycles see committed state.
    function automatic logic [DW-1:0] exp_op(input regName_t rs, input logic held);
        if (rs == '0) return '0;
        if (!held && wb_wen && (wb_rd == rs)) return wb_data;
        return m_regs[rs];
    endfunction

    task automatic model_compare();
        logic exp_ready;
        exp_ready = !m_valid || ex_ready;
        check("ex_valid", ex_valid, m_valid);
        check("dec_ready", dec_ready, exp_ready);
        if (m_valid) begin
            check("ex_op_a", ex_op_a, exp_op(m_rs1, m_held));
            check("ex_op_b", ex_op_b, exp_op(m_rs2, m_held));
            check("ex_rd", ex_rd, m_rd);
            check("ex_imm", ex_imm, m_imm);
            check("ex_ctrl", ex_ctrl, m_ctrl);
        end
        if (dec_valid && exp_ready) begin
            check("rf_rs1_acc", rf_rs1, dec_rs1);
            check("rf_rs2_acc", rf_rs2, dec_rs2);
        end else if (m_valid) begin
            check("rf_rs1_held", rf_rs1, m_rs1);
            check("rf_rs2_held", rf_rs2, m_rs2);
        end
`ifdef OPERAND_FETCH_STALL_CNT_EN
        check("stall_cnt", stall_cnt, m_stall);
`endif
    endtask

    // Drive one cycle's inputs (called just after a falling edge) and compare.
    task automatic drive(input logic dv, input regName_t r1, input regName_t r2, input regName_t rd,
                         input logic [DW-1:0] imm, input logic [CW-1:0] ctrl, input logic er,
                         input logic wen, input regName_t wrd, input logic [DW-1:0] wd);
        dec_valid = dv; dec_rs1 = r1; dec_rs2 = r2; dec_rd = rd;
        dec_imm = imm; dec_ctrl = ctrl; ex_ready = er;
        wb_wen = wen; wb_rd = wrd; wb_data = wd;
        #1;
        model_compare();
    endtask

    task automatic drive_idle(input logic er, input logic wen, input regName_t wrd, input logic [DW-1:0] wd);
        drive(1'b0, '0, '0, '0, '0, '0, er, wen, wrd, wd);
    endtask

    // Advance the model across the rising edge and move to the next falling edge.
    task automatic step();
        logic acc;
        acc = dec_valid && (!m_valid || ex_ready);
        if (m_valid && !ex_ready) m_stall++;
        if (acc) begin
            m_valid = 1'b1; m_held = 1'b0;
            m_rs1 = dec_rs1; m_rs2 = dec_rs2; m_rd = dec_rd;
            m_imm = dec_imm; m_ctrl = dec_ctrl;
        end else if (m_valid && ex_ready) begin
            m_valid = 1'b0;
        end else if (m_valid) begin
            m_held = 1'b1;
        end
        if (wb_wen) m_regs[wb_rd] = wb_data;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        dec_valid = 1'b0; ex_ready = 1'b0; wb_wen = 1'b0;
        m_valid = 1'b0; m_held = 1'b0; m_stall = 0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    logic [DW-1:0] exp_a2 [4];
    logic [DW-1:0] exp_b2 [4];

    initial begin
        for (int i = 0; i < REG_COUNT; i++) m_regs[i] = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_imm = '0; m_ctrl = '0;
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; dec_imm = '0; dec_ctrl = '0;
        wb_rd = '0; wb_data = '0;
        rstN = 1'b0; dec_valid = 1'b0; ex_ready = 1'b0; wb_wen = 1'b0;
        #1;
        check("rst_ex_valid", ex_valid, 1'b0);
        check("rst_dec_ready", dec_ready, 1'b0);
        check("rst_rf_rs1", rf_rs1, 5'd0);
        check("rst_rf_rs2", rf_rs2, 5'd0);
        do_reset();

        // Preload x0..x8 (x0 written 0 so the RF has defined content everywhere used).
        for (int i = 0; i <= 8; i++) begin
            drive_idle(1'b1, 1'b1, regName_t'(i), (i == 0) ? 32'h0 : 32'h100 + i);
            step();
        end

        // Scenario 1: basic fetch with preloaded x5/x6.
        drive_idle(1'b1, 1'b1, 5'd5, 32'h11); step();
        drive_idle(1'b1, 1'b1, 5'd6, 32'h22); step();
        drive(1'b1, 5'd5, 5'd6, 5'd7, 32'h1234, 16'hBEEF, 1'b1, 1'b0, '0, '0);
        check("s1_acc_ready", dec_ready, 1'b1);
        step();
        drive_idle(1'b1, 1'b0, '0, '0);
        check("s1_valid", ex_valid, 1'b1);
        check("s1_op_a", ex_op_a, 32'h11);
        check("s1_op_b", ex_op_b, 32'h22);
        check("s1_imm", ex_imm, 32'h1234);
        check("s1_ctrl", ex_ctrl, 16'hBEEF);
        check("s1_rd", ex_rd, 5'd7);
        step();
        drive_idle(1'b1, 1'b0, '0, '0);
        check("s1_drain", ex_valid, 1'b0);
        step();

        // Scenario 2: four back-to-back accepts at full throughput.
        exp_a2 = '{32'h101, 32'h103, 32'h11, 32'h107};
        exp_b2 = '{32'h102, 32'h104, 32'h22, 32'h108};
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) drive(1'b1, regName_t'(2*i+1), regName_t'(2*i+2), regName_t'(i),
                             32'(i), 16'(i), 1'b1, 1'b0, '0, '0);
            else drive_idle(1'b1, 1'b0, '0, '0);
            if (i < 4) check("s2_dec_ready", dec_ready, 1'b1);
            if (i > 0) begin
                check("s2_valid", ex_valid, 1'b1);
                check("s2_op_a", ex_op_a, exp_a2[i-1]);
                check("s2_op_b", ex_op_b, exp_b2[i-1]);
            end
            step();
        end

        // Scenario 3: write on the accept edge, then a live write during the first cycle.
        drive(1'b1, 5'd5, 5'd6, 5'd1, '0, '0, 1'b1, 1'b1, 5'd5, 32'hAA); step();
        drive_idle(1'b1, 1'b0, '0, '0);
        check("s3_capt_a", ex_op_a, 32'hAA);
        step();
        drive(1'b1, 5'd5, 5'd6, 5'd1, '0, '0, 1'b1, 1'b0, '0, '0); step();
        drive_idle(1'b1, 1'b1, 5'd5, 32'hBB);
        check("s3_live_a", ex_op_a, 32'hBB);
        step();

        // Scenario 5: x0 never bypasses.
        drive(1'b1, 5'd0, 5'd6, 5'd2, '0, '0, 1'b1, 1'b1, 5'd0, 32'hFF); step();
        drive_idle(1'b1, 1'b0, '0, '0);
        check("s5_x0_a", ex_op_a, 32'h0);
        step();

        // Scenario 4: stall with a writeback snooped into the held operand.
        drive(1'b1, 5'd5, 5'd6, 5'd3, '0, '0, 1'b1, 1'b0, '0, '0); step();
        drive_idle(1'b0, 1'b0, '0, '0);
        check("s4_read_a", ex_op_a, 32'hBB);
        check("s4_read_b", ex_op_b, 32'h22);
        check("s4_ready0", dec_ready, 1'b0);
        step();
        drive_idle(1'b0, 1'b1, 5'd6, 32'h55);
        check("s4_pre_b", ex_op_b, 32'h22);
        step();
        drive_idle(1'b0, 1'b0, '0, '0);
        check("s4_snoop_b", ex_op_b, 32'h55);
        check("s4_hold_a", ex_op_a, 32'hBB);
        check("s4_hold_ready", dec_ready, 1'b0);
        step();
        drive_idle(1'b1, 1'b0, '0, '0);
        check("s4_done_valid", ex_valid, 1'b1);
        check("s4_done_b", ex_op_b, 32'h55);
        step();
        drive_idle(1'b1, 1'b0, '0, '0);
        check("s4_idle", ex_valid, 1'b0);
        step();

        // Random traffic over a small register window to force hazards.
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(99) < 70), regName_t'($urandom_range(7)), regName_t'($urandom_range(7)),
                  regName_t'($urandom_range(31)), $urandom, 16'($urandom),
                  1'($urandom_range(99) < 65), 1'($urandom_range(1)),
                  regName_t'($urandom_range(7)), $urandom);
            step();
        end

        // Scenario 6: asynchronous reset in the middle of a hold.
        drive_idle(1'b1, 1'b0, '0, '0); step();
        drive_idle(1'b1, 1'b0, '0, '0); step();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 5'd4, '0, '0, 1'b0, 1'b0, '0, '0); step();
        for (int i = 0; i < 3; i++) begin
            drive_idle(1'b0, 1'b0, '0, '0);
            step();
        end
        drive_idle(1'b0, 1'b0, '0, '0);
        check("s6_pre_valid", ex_valid, 1'b1);
`ifdef OPERAND_FETCH_STALL_CNT_EN
        check("s6_pre_stall", stall_cnt, 32'd3);
`endif
        #2;
        rstN = 1'b0;
        #1;
        check("s6_rst_valid", ex_valid, 1'b0);
        check("s6_rst_ready", dec_ready, 1'b0);
        check("s6_rst_rf_rs1", rf_rs1, 5'd0);
`ifdef OPERAND_FETCH_STALL_CNT_EN
        check("s6_rst_stall", stall_cnt, 32'd0);
`endif
        m_valid = 1'b0; m_held = 1'b0; m_stall = 0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        drive_idle(1'b1, 1'b0, '0, '0);
        check("s6_after_valid", ex_valid, 1'b0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
